// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: execute-stage data-memory access controller.
// Base+displacement addressing (offset / pre-update / post-update), whole-access
// bounds check before any memory command, ready/valid command port, in-order
// read-beat collection, completion pulse with optional base writeback.
// Optional feature macro: MEM_ACCESS_STATS_EN (saturating access/fault counters).
module mem_access_ctrl #(
  parameter int WORD_WIDTH    = 48,
  parameter int DM_WORDS      = 16384,
  parameter int ADDR_WIDTH    = $clog2(DM_WORDS),
  parameter int REG_IDX_WIDTH = 3,
  parameter int BURST_MAX     = 4,
  parameter int CNT_WIDTH     = $clog2(BURST_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_mode,
  input  logic [WORD_WIDTH-1:0]    req_base,
  input  logic [WORD_WIDTH-1:0]    req_disp,
  input  logic [REG_IDX_WIDTH-1:0] req_base_idx,
  input  logic [CNT_WIDTH-1:0]     req_count,
  input  logic [WORD_WIDTH-1:0]    req_wdata,
  output logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [WORD_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [WORD_WIDTH-1:0]    mem_rdata,
  output logic                     ld_valid,
  output logic [CNT_WIDTH-1:0]     ld_beat,
  output logic [WORD_WIDTH-1:0]    ld_data,
  output logic                     done,
  output logic                     fault,
  output logic                     wb_en,
  output logic [REG_IDX_WIDTH-1:0] wb_idx,
  output logic [WORD_WIDTH-1:0]    wb_value,
  output logic [31:0]              stat_access_count,
  output logic [31:0]              stat_fault_count
);

  localparam int XW = WORD_WIDTH + 1;
  localparam logic [XW-1:0]        DM_LIMIT  = XW'(DM_WORDS);
  localparam logic [CNT_WIDTH-1:0] BURST_LIM = CNT_WIDTH'(BURST_MAX);
  localparam logic [1:0] MODE_PRE  = 2'b01;
  localparam logic [1:0] MODE_POST = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t state_reg, state_next;

  logic                     we_reg;
  logic [ADDR_WIDTH-1:0]    start_reg;
  logic [CNT_WIDTH-1:0]     count_reg;
  logic [WORD_WIDTH-1:0]    wdata_reg;
  logic [REG_IDX_WIDTH-1:0] idx_reg;
  logic [WORD_WIDTH-1:0]    wb_value_reg;
  logic                     wb_reg;
  logic                     fault_reg;
  logic [CNT_WIDTH-1:0]     beat_reg;
  logic [CNT_WIDTH-1:0]     rbeat_reg;
  logic [CNT_WIDTH-1:0]     outst_reg, outst_next;
  logic                     ld_valid_reg;
  logic [CNT_WIDTH-1:0]     ld_beat_reg;
  logic [WORD_WIDTH-1:0]    ld_data_reg;

  // Request decode is done at one extra bit so that under/overflow of the
  // effective address and of the burst end are both visible as bit WORD_WIDTH.
  logic [XW-1:0] ea_ext, start_ext, last_ext;
  logic          req_fault, req_wb;

  assign ea_ext    = {1'b0, req_base} + {req_disp[WORD_WIDTH-1], req_disp};
  assign start_ext = (req_mode == MODE_POST) ? {1'b0, req_base} : ea_ext;
  assign last_ext  = start_ext + XW'(req_count) - XW'(1);

  assign req_fault = ea_ext[WORD_WIDTH]
                  || (last_ext >= DM_LIMIT)
                  || (req_mode == MODE_RSVD)
                  || (req_count == '0)
                  || (req_count > BURST_LIM)
                  || (req_we && (req_count != CNT_WIDTH'(1)));

  // Register 0 is never written back, so an update on it is silently dropped.
  assign req_wb = !req_fault
               && ((req_mode == MODE_PRE) || (req_mode == MODE_POST))
               && (req_base_idx != '0);

  logic accept, cmd_fire, rd_fire, rv_take, last_beat;

  assign accept    = (state_reg == IDLE) && req_valid;
  assign cmd_fire  = (state_reg == ISSUE) && mem_ready;
  assign rd_fire   = cmd_fire && !we_reg;
  // Beats with nothing outstanding (stray, or left over from before a reset) are dropped.
  assign rv_take   = mem_rvalid && (outst_reg != '0);
  assign last_beat = (beat_reg == count_reg - CNT_WIDTH'(1));

  assign ld_valid = ld_valid_reg;
  assign ld_beat  = ld_beat_reg;
  assign ld_data  = ld_data_reg;

  // Outstanding read count: issue and return in the same cycle cancel out.
  always_comb begin
    outst_next = outst_reg;
    if (rd_fire && !rv_take) begin
      outst_next = outst_reg + CNT_WIDTH'(1);
    end else if (!rd_fire && rv_take) begin
      outst_next = outst_reg - CNT_WIDTH'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and port outputs; completion fields are only driven while done.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done       = 1'b0;
    fault      = 1'b0;
    wb_en      = 1'b0;
    wb_idx     = '0;
    wb_value   = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_fault ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = we_reg;
        mem_addr  = start_reg + ADDR_WIDTH'(beat_reg);
        mem_wdata = wdata_reg;
        if (mem_ready && last_beat) begin
          if (we_reg || (outst_next == '0)) begin
            state_next = DONE;
          end else begin
            state_next = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        // Leaving on the returning beat makes done coincide with the last ld_valid.
        if (outst_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        fault      = fault_reg;
        wb_en      = wb_reg;
        wb_idx     = idx_reg;
        wb_value   = wb_value_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, beat counters and registered load-beat output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg       <= 1'b0;
      start_reg    <= '0;
      count_reg    <= '0;
      wdata_reg    <= '0;
      idx_reg      <= '0;
      wb_value_reg <= '0;
      wb_reg       <= 1'b0;
      fault_reg    <= 1'b0;
      beat_reg     <= '0;
      rbeat_reg    <= '0;
      outst_reg    <= '0;
      ld_valid_reg <= 1'b0;
      ld_beat_reg  <= '0;
      ld_data_reg  <= '0;
    end else begin
      outst_reg    <= outst_next;
      ld_valid_reg <= rv_take;
      if (rv_take) begin
        ld_data_reg <= mem_rdata;
        ld_beat_reg <= rbeat_reg;
        rbeat_reg   <= rbeat_reg + CNT_WIDTH'(1);
      end
      if (cmd_fire) begin
        beat_reg <= beat_reg + CNT_WIDTH'(1);
      end
      if (accept) begin
        we_reg       <= req_we;
        start_reg    <= start_ext[ADDR_WIDTH-1:0];
        count_reg    <= req_count;
        wdata_reg    <= req_wdata;
        idx_reg      <= req_base_idx;
        wb_value_reg <= ea_ext[WORD_WIDTH-1:0];
        wb_reg       <= req_wb;
        fault_reg    <= req_fault;
        beat_reg     <= '0;
        rbeat_reg    <= '0;
      end
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  genvar gi;
  // Counter 0 tallies clean completions, counter 1 tallies rejected requests.
  for (gi = 0; gi < 2; gi++) begin : g_stat
    logic [31:0] cnt_reg;
    // Saturating count of completions with the matching outcome.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if ((state_reg == DONE) && (fault_reg == 1'(gi)) && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end
  assign stat_access_count = g_stat[0].cnt_reg;
  assign stat_fault_count  = g_stat[1].cnt_reg;
`else
  assign stat_access_count = '0;
  assign stat_fault_count  = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scenarios plus randomized requests against a
// behavioural model of addressing, faults, memory traffic and load beats.
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_mode;
  logic [47:0] req_base, req_disp, req_wdata;
  logic [2:0]  req_base_idx, req_count;
  logic        mem_req, mem_ready, mem_we, mem_rvalid;
  logic [13:0] mem_addr;
  logic [47:0] mem_wdata, mem_rdata;
  logic        ld_valid;
  logic [2:0]  ld_beat;
  logic [47:0] ld_data;
  logic        done, fault, wb_en;
  logic [2:0]  wb_idx;
  logic [47:0] wb_value;
  logic [31:0] stat_access_count, stat_fault_count;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_mode(req_mode),
    .req_base(req_base), .req_disp(req_disp), .req_base_idx(req_base_idx),
    .req_count(req_count), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_beat(ld_beat), .ld_data(ld_data),
    .done(done), .fault(fault), .wb_en(wb_en), .wb_idx(wb_idx), .wb_value(wb_value),
    .stat_access_count(stat_access_count), .stat_fault_count(stat_fault_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int addr; logic we; logic [47:0] wdata; } cmd_t;
  typedef struct { int beat; logic [47:0] data; } beat_t;
  typedef struct { int due; logic [47:0] data; } rd_t;

  cmd_t        exp_cmd[$];
  beat_t       exp_ld[$];
  rd_t         pend[$];
  bit          ready_q[$];
  logic [47:0] mem_img [int];

  int n_checks = 0, n_errors = 0;
  int cyc = 0, n_cmds = 0, fixed_lat = -1;
  int exp_acc = 0, exp_flt = 0;
  bit always_rdy = 1, always_rv = 1, quiet = 0, stray = 0, done_seen = 0;
  logic        exp_fault, exp_wb_en;
  logic [2:0]  exp_wb_idx;
  logic [47:0] exp_wb_value;
  logic        got_fault, got_wb_en, got_ready;
  logic [2:0]  got_idx;
  logic [47:0] got_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [47:0] rd_data(input int a);
    if (mem_img.exists(a)) return mem_img[a];
    return 48'h5A5A_0000_0000 ^ 48'(a * 40503);
  endfunction

  // One clock of bench activity at the falling edge: memory handshake,
  // load-beat and completion observation, then read-return drive.
  task automatic tick();
    cmd_t c;
    rd_t  r;
    int   lat;
    @(negedge clk);
    cyc++;
    if (mem_req && ready_q.size() > 0) mem_ready = ready_q.pop_front();
    else mem_ready = always_rdy ? 1'b1 : 1'($urandom_range(0, 1));
    if (mem_req && mem_ready) begin
      n_cmds++;
      if (exp_cmd.size() == 0) begin
        chk("cmd_unexp", mem_req, 0);
      end else begin
        c = exp_cmd.pop_front();
        chk("cmd_addr", mem_addr, c.addr);
        chk("cmd_we", mem_we, c.we);
        if (c.we) begin
          chk("cmd_wdata", mem_wdata, c.wdata);
          mem_img[c.addr] = c.wdata;
        end else begin
          lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
          pend.push_back('{due: cyc + 1 + lat, data: rd_data(c.addr)});
        end
      end
    end
    if (quiet) chk("quiet_ld", ld_valid, 0);
    else if (ld_valid) begin
      if (exp_ld.size() == 0) begin
        chk("ld_unexp", ld_valid, 0);
      end else begin
        chk("ld_beat", ld_beat, exp_ld[0].beat);
        chk("ld_data", ld_data, exp_ld[0].data);
        void'(exp_ld.pop_front());
      end
    end
    if (done) begin
      done_seen = 1;
      got_fault = fault;
      got_wb_en = wb_en;
      got_idx   = wb_idx;
      got_val   = wb_value;
      got_ready = req_ready;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 48'({$urandom(), $urandom()});
    if (pend.size() > 0 && pend[0].due <= cyc && (always_rv || $urandom_range(0, 1) == 1)) begin
      r = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = r.data;
    end else if (stray) begin
      mem_rvalid = 1'b1;
    end
  endtask

  // Build the expected outcome from the addressing rules, then present the request.
  task automatic send_req(input logic we, input logic [1:0] mode, input logic [47:0] base,
                          input logic [47:0] disp, input logic [2:0] idx,
                          input logic [2:0] count, input logic [47:0] wdata);
    longint sd, ea, start, lim;
    lim   = longint'(1) << 48;
    sd    = {{16{disp[47]}}, disp};
    ea    = longint'({16'b0, base}) + sd;
    start = (mode == 2'd2) ? longint'({16'b0, base}) : ea;
    exp_fault = (ea < 0) || (ea >= lim) || (mode == 2'd3) || (count == 0) || (count > 4)
             || (we && count != 1) || (start + longint'(count) - 1 >= 16384);
    exp_wb_en    = !exp_fault && (mode == 2'd1 || mode == 2'd2) && (idx != 0);
    exp_wb_idx   = idx;
    exp_wb_value = 48'(ea);
    exp_cmd.delete();
    exp_ld.delete();
    if (!exp_fault) begin
      for (int b = 0; b < int'(count); b++) begin
        exp_cmd.push_back('{addr: int'(start) + b, we: we, wdata: wdata});
        if (!we) exp_ld.push_back('{beat: b, data: rd_data(int'(start) + b)});
      end
    end
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    chk("req_ready_wait", req_ready, 1);
    $display("txn we=%0d mode=%0d base=%0d disp=%0d idx=%0d cnt=%0d exp_fault=%0d",
             we, mode, base, $signed(disp), idx, count, exp_fault);
    req_we = we; req_mode = mode; req_base = base; req_disp = disp;
    req_base_idx = idx; req_count = count; req_wdata = wdata;
    req_valid = 1'b1;
    n_cmds = 0;
    done_seen = 0;
  endtask

  task automatic check_stats();
`ifdef MEM_ACCESS_STATS_EN
    chk("stat_access", stat_access_count, exp_acc);
    chk("stat_fault", stat_fault_count, exp_flt);
`else
    chk("stat_access", stat_access_count, 0);
    chk("stat_fault", stat_fault_count, 0);
`endif
  endtask

  // Run to completion and compare the done fields; exp_lat>0 also checks latency.
  task automatic finish_req(input int exp_lat);
    int n;
    for (n = 1; n <= 300; n++) begin
      tick();
      if (n == 1) req_valid = 1'b0;
      if (done_seen) break;
    end
    chk("done_seen", done_seen, 1);
    if (!done_seen) return;
    if (exp_lat > 0) chk("latency", n, exp_lat);
    chk("fault", got_fault, exp_fault);
    chk("wb_en", got_wb_en, exp_wb_en);
    if (exp_wb_en) begin
      chk("wb_idx", got_idx, exp_wb_idx);
      chk("wb_value", got_val, exp_wb_value);
    end
    chk("ready_at_done", got_ready, 0);
    chk("cmds_left", exp_cmd.size(), 0);
    chk("beats_left", exp_ld.size(), 0);
    if (exp_fault) chk("fault_no_cmd", n_cmds, 0);
    if (exp_fault) exp_flt++; else exp_acc++;
    tick();
    chk("ready_after", req_ready, 1);
    check_stats();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] base, disp;
    logic [2:0]  cnt;
    logic        we;
    int          di, r;
    rst = 1'b1; req_valid = 0; req_we = 0; req_mode = 0; req_base = 0; req_disp = 0;
    req_base_idx = 0; req_count = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_wb_value", wb_value, 0);
    rst = 1'b0;

    // Offset load, memory answers after two cycles.
    mem_img[96] = 48'hABC; fixed_lat = 2;
    send_req(0, 2'd0, 48'd100, -48'sd4, 3'd1, 3'd1, 48'd0);
    finish_req(0);
    fixed_lat = -1;

    // Post-update store with memory always ready.
    send_req(1, 2'd2, 48'd10, 48'd3, 3'd2, 3'd1, 48'h55);
    finish_req(2);

    // Pre-update burst at the top of memory with a stalling ready pattern.
    ready_q = '{1, 0, 1, 1, 1};
    send_req(0, 2'd1, 48'd16380, 48'd0, 3'd3, 3'd4, 48'd0);
    finish_req(0);
    ready_q.delete();

    // Rejected requests.
    send_req(0, 2'd0, 48'd16382, 48'd0, 3'd1, 3'd4, 48'd0);  finish_req(1);
    send_req(0, 2'd0, 48'd2, -48'sd3, 3'd1, 3'd1, 48'd0);    finish_req(1);
    send_req(0, 2'd3, 48'd50, 48'd0, 3'd1, 3'd1, 48'd0);     finish_req(1);
    send_req(1, 2'd0, 48'd50, 48'd0, 3'd1, 3'd2, 48'h7);     finish_req(1);

    // Pre-update on register 0, then a stray read beat while idle.
    send_req(0, 2'd1, 48'd40, 48'd2, 3'd0, 3'd1, 48'd0);
    finish_req(0);
    stray = 1; tick(); stray = 0; tick();
    chk("stray_ld", ld_valid, 0);

    // Reset while two reads are outstanding, then let them arrive.
    fixed_lat = 20;
    send_req(0, 2'd0, 48'd500, 48'd0, 3'd1, 3'd2, 48'd0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) req_valid = 1'b0;
      if (exp_cmd.size() == 0) break;
    end
    tick();
    chk("wait_no_done", done, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_mem_req", mem_req, 0);
    tick();
    rst = 1'b0;
    exp_cmd.delete(); exp_ld.delete(); exp_acc = 0; exp_flt = 0;
    quiet = 1;
    repeat (25) tick();
    quiet = 0;
    fixed_lat = -1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_done", done, 0);
    chk("post_rst_wb_en", wb_en, 0);
    check_stats();

    // One good and one bad request after reset.
    send_req(0, 2'd0, 48'd200, 48'd5, 3'd4, 3'd1, 48'd0);  finish_req(0);
    send_req(0, 2'd3, 48'd200, 48'd5, 3'd4, 3'd1, 48'd0);  finish_req(1);

    // Randomized requests with random ready/return timing.
    always_rv = 0;
    for (int t = 0; t < 150; t++) begin
      always_rdy = ($urandom_range(0, 3) == 0);
      we  = ($urandom_range(0, 2) == 0);
      cnt = we ? (($urandom_range(0, 9) == 0) ? 3'd2 : 3'd1) : 3'($urandom_range(0, 5));
      r = $urandom_range(0, 9);
      if (r == 0)      base = 48'(16384 - int'($urandom_range(0, 6)));
      else if (r == 1) base = 48'({$urandom(), $urandom()});
      else             base = 48'($urandom_range(0, 16383));
      if ($urandom_range(0, 9) == 0) disp = 48'({$urandom(), $urandom()});
      else begin
        di = int'($urandom_range(0, 60)) - 30;
        disp = 48'(di);
      end
      send_req(we, 2'($urandom_range(0, 3)), base, disp, 3'($urandom_range(0, 7)),
               cnt, 48'({$urandom(), $urandom()}));
      finish_req(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
